ram_rd_check: RTL
=================

RAM_RD_CHECK -- requirements
Module: ram_rd_check

Interface
REQ-001 Parameter DEPTH, default 32: number of RAM words read per pass.
REQ-002 Parameter ADDR_W, default 5: RAM address width; DEPTH SHALL be no greater than 2**ADDR_W.
REQ-003 Parameter DATA_W, default 8: RAM data width.
REQ-004 Port sys_clk, input, 1: single clock; all logic SHALL be rising-edge sys_clk.
REQ-005 Port sys_rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port rd_start, input, 1: one-cycle pulse from the writer side that starts a read pass.
REQ-007 Port ram_en, output, 1: RAM port enable.
REQ-008 Port ram_we, output, 1: RAM write enable; SHALL always be 0.
REQ-009 Port ram_addr, output, ADDR_W: RAM read address.
REQ-010 Port ram_rd_data, input, DATA_W: RAM read data, valid exactly one cycle after ram_en=1 with an address.
REQ-011 Port rd_valid, output, 1: high for one cycle per word returned.
REQ-012 Port rd_data, output, DATA_W: registered copy of the word returned; qualified by rd_valid.
REQ-013 Port busy, output, 1: high from the cycle after an accepted rd_start until done.
REQ-014 Port done, output, 1: one-cycle pulse at the end of a pass.
REQ-015 Port err_flag, output, 1: sticky mismatch flag for the current pass.
REQ-016 Port err_cnt, output, 8: number of mismatching words in the current pass.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, DRAIN and DONE.
REQ-018 IDLE -> READ on rd_start=1; rd_start SHALL be ignored in every other state.
REQ-019 READ: ram_en=1; ram_addr SHALL go 0,1,...,DEPTH-1, one per cycle; after address DEPTH-1 the FSM SHALL go to DRAIN.
REQ-020 DRAIN: ram_en=0 for exactly one cycle, so that the last word returns; then the FSM SHALL go to DONE.
REQ-021 DONE: done=1 for one cycle; then the FSM SHALL go to IDLE; busy SHALL fall in the same cycle that done rises.
REQ-022 rd_valid and rd_data SHALL be registered from ram_rd_data, so rd_valid occurs 2 cycles after the matching ram_addr is presented.
REQ-023 Exactly DEPTH rd_valid pulses SHALL occur per pass, and no pulse SHALL occur outside READ/DRAIN/DONE.
REQ-024 The expected word for address A SHALL be A zero-extended or truncated to DATA_W; this is the pattern the writer stores.
REQ-025 On a mismatch, err_flag SHALL be set and err_cnt SHALL increment, saturating at 255.
REQ-026 err_flag and err_cnt SHALL clear on an accepted rd_start and hold their values after done until the next pass.
REQ-027 ram_addr SHALL wrap to 0 on entry to DRAIN and SHALL hold 0 in IDLE.

Reset
REQ-028 When sys_rst_n=0 at a rising edge: state=IDLE; ram_en, ram_we, ram_addr, rd_valid, rd_data, busy, done, err_flag and err_cnt SHALL all be 0.
REQ-029 A reset during a pass SHALL abort it with no done pulse; ram_en SHALL be 0 from the next edge.
REQ-030 An rd_start that coincides with sys_rst_n=0 SHALL be ignored.

Configuration
REQ-031 Macro RD_CHECK_EN, when defined, SHALL compile in the comparison logic of REQ-024 to REQ-026.
REQ-032 When RD_CHECK_EN is undefined, err_flag and err_cnt SHALL be constant 0, and read sequencing and rd_valid/rd_data SHALL be unchanged.

Verification
REQ-033 RAM model with mem[A]=A, reset released at 200 ns, rd_start at 300 ns -> 32 rd_valid pulses with rd_data 0..31 in order, done 35 cycles after rd_start, err_flag=0, err_cnt=0.
REQ-034 Model with mem[5]=8'hFF and mem[17]=8'h00 -> err_flag=1 and err_cnt=2 at done, and rd_data=8'hFF on the 6th rd_valid pulse.
REQ-035 rd_start pulsed again at address 10 mid-pass -> no restart, exactly 32 rd_valid pulses, and a single done pulse.
REQ-036 sys_rst_n=0 for 1 cycle at address 12 -> all outputs 0 the next cycle, no done pulse; a new rd_start then completes a clean pass.
REQ-037 All 32 words corrupted, then a second pass on the same corrupted memory -> err_cnt=32 after each pass, confirming the clear at start.
REQ-038 Build without RD_CHECK_EN using corrupted memory -> err_flag=0 and err_cnt=0, while the rd_data sequence still matches the memory contents.

Source files
------------

// File: rtl/ram_rd_check_if.sv
// RAM read-check bus: start/RAM port/result signals for ram_rd_check.
// master = checker side, slave = RAM/writer/environment side.
interface ram_rd_check_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              rd_start;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              err_flag;
  logic [7:0]        err_cnt;

  modport master (
    input  rd_start, ram_rd_data,
    output ram_en, ram_we, ram_addr,
    output rd_valid, rd_data,
    output busy, done, err_flag, err_cnt
  );

  modport slave (
    output rd_start, ram_rd_data,
    input  ram_en, ram_we, ram_addr,
    input  rd_valid, rd_data,
    input  busy, done, err_flag, err_cnt
  );
endinterface

// File: rtl/ram_rd_check.sv
// Sequential RAM read pass with optional pattern check (mem[A] == A).
// Define RD_CHECK_EN to build the comparison / error counting logic.
module ram_rd_check #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  ram_rd_check_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t state;
  state_t state_n;
  logic   start_acc;
  logic   en_d;

  assign start_acc  = bus.rd_start && (state == IDLE);
  assign bus.ram_we = 1'b0;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start_acc) state_n = READ;
      READ:  if (bus.ram_addr == LAST) state_n = DRAIN;
      DRAIN: state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // en_d marks the cycle the RAM word is on ram_rd_data
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      bus.ram_en   <= 1'b0;
      bus.ram_addr <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      en_d         <= 1'b0;
    end else begin
      bus.ram_en   <= (state_n == READ);
      bus.ram_addr <= (state == READ && state_n == READ)
                    ? bus.ram_addr + 1'b1 : '0;
      bus.busy     <= (state_n != IDLE);
      bus.done     <= (state == DONE);
      en_d         <= bus.ram_en;
      bus.rd_valid <= en_d;
      if (en_d) bus.rd_data <= bus.ram_rd_data;
    end
  end

`ifdef RD_CHECK_EN
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] exp_word;

  assign exp_word = DATA_W'(addr_d);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      addr_d       <= '0;
      bus.err_flag <= 1'b0;
      bus.err_cnt  <= '0;
    end else begin
      addr_d <= bus.ram_addr;
      if (start_acc) begin
        bus.err_flag <= 1'b0;
        bus.err_cnt  <= '0;
      end else if (en_d && bus.ram_rd_data != exp_word) begin
        bus.err_flag <= 1'b1;
        if (bus.err_cnt != 8'hFF)
          bus.err_cnt <= bus.err_cnt + 1'b1;
      end
    end
  end
`else
  assign bus.err_flag = 1'b0;
  assign bus.err_cnt  = '0;
`endif

endmodule
